// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller and the
// decode-side logic around it.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    ERROR    = 2'd3
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Decoder drives id_uses_rs2 for R_TYPE, SW and BR.
  localparam logic [6:0] R_TYPE = 7'b0110011;
  localparam logic [6:0] I_TYPE = 7'b0010011;
  localparam logic [6:0] LW     = 7'b0000011;
  localparam logic [6:0] SW     = 7'b0100011;
  localparam logic [6:0] BR     = 7'b1100011;

endpackage

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
// Writes to x0 are never a hazard.
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       lu
);

  assign lu = ex_memread && (ex_rd != REG_ZERO) &&
              ((ex_rd == id_rs1) || (id_uses_rs2 && (ex_rd == id_rs2)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Per-cycle advance/stall/bubble/flush sequencing for the 5-stage pipeline,
// with saturating stall/flush counters and a sticky memory-timeout error.
//
//   state    | meaning
//   RUN      | normal issue; branch/load-use/memory rules evaluated
//   FLUSH    | squashing wrong-path fetches after a taken branch
//   MEM_WAIT | data memory busy; front of pipe frozen, timer running
//   ERROR    | memory never answered; frozen until reset
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 16,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_memread,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             stage_hold,
  output logic             mem_wb_bubble,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [2:0]       FCNT_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [8:0]       TIMEOUT   = 9'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  hz_state_e  state_q, state_d, act_state;
  logic [2:0] fcnt_q, fcnt_d;
  logic [7:0] timer_q, timer_d;
  logic       ret_flush_q, ret_flush_d;
  logic       lu, mem_block;

  load_use_detect u_lu (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_memread  (ex_memread),
    .lu          (lu)
  );

  assign mem_block = mem_req && !mem_ready;

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    stage_hold    = 1'b0;
    mem_wb_bubble = 1'b0;
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    timer_d       = timer_q;
    ret_flush_d   = ret_flush_q;

    // The cycle memory answers behaves like the state the wait interrupted.
    act_state = state_q;
    if (state_q == MEM_WAIT && mem_ready) act_state = ret_flush_q ? FLUSH : RUN;

    case (act_state)
      RUN: begin
        state_d = RUN;
        if (mem_block) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          stage_hold    = 1'b1;
          mem_wb_bubble = 1'b1;
          state_d       = MEM_WAIT;
          timer_d       = 8'd1;
          ret_flush_d   = 1'b0;
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            fcnt_d  = FCNT_INIT;
          end
        end else if (lu) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_flush = 1'b1;
        end
      end
      FLUSH: begin
        if (mem_block) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          stage_hold    = 1'b1;
          mem_wb_bubble = 1'b1;
          state_d       = MEM_WAIT;
          timer_d       = 8'd1;
          ret_flush_d   = 1'b1;
        end else begin
          if_id_flush = 1'b1;
          id_ex_flush = 1'b1;
          fcnt_d      = fcnt_q - 3'd1;
          state_d     = (fcnt_q <= 3'd1) ? RUN : FLUSH;
        end
      end
      MEM_WAIT: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        stage_hold    = 1'b1;
        mem_wb_bubble = 1'b1;
        timer_d       = timer_q + 8'd1;
        if (({1'b0, timer_q} + 9'd1) >= TIMEOUT) state_d = ERROR;
      end
      ERROR: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        stage_hold    = 1'b1;
        mem_wb_bubble = 1'b1;
      end
    endcase

    // While reset is held, keep the front of the pipe cleared.
    if (!reset) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      stage_hold    = 1'b0;
      mem_wb_bubble = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= RUN;
      fcnt_q          <= 3'd0;
      timer_q         <= 8'd0;
      ret_flush_q     <= 1'b0;
      stall_count     <= '0;
      flush_count     <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      fcnt_q      <= fcnt_d;
      timer_q     <= timer_d;
      ret_flush_q <= ret_flush_d;
      if (!pc_write && (stall_count != '1)) stall_count <= stall_count + CNT_ONE;
      if (if_id_flush && (flush_count != '1)) flush_count <= flush_count + CNT_ONE;
      if (state_d == ERROR) mem_timeout_err <= 1'b1;
    end
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Sequences the 5-stage RISC-V pipeline around the main opcode decoder.
- Decides each cycle whether the pipeline advances, stalls, bubbles or flushes, from three inputs: load-use hazards, taken branches and data-memory handshake waits.
- Drives PC/IF-ID write enables, flush/bubble controls and a global stage hold.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout error.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive flush cycles after a taken branch (legal range 1..7).
- MEM_TIMEOUT, 16, number of MEM_WAIT cycles without mem_ready before entering ERROR (legal range 2..255).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- id_rs1  in  5  rs1 of the instruction in ID.
- id_rs2  in  5  rs2 of the instruction in ID.
- id_uses_rs2  in  1  the ID instruction reads rs2 (R-type, SW, BEQ).
- ex_rd  in  5  destination register of the instruction in EX.
- ex_memread  in  1  the EX instruction is a load.
- ex_branch_taken  in  1  the branch in EX resolved taken.
- mem_req  in  1  the MEM-stage instruction accesses data memory.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC register load enable.
- if_id_write  out  1  IF/ID register load enable.
- if_id_flush  out  1  clear IF/ID to NOP.
- id_ex_flush  out  1  zero the ID/EX control fields (bubble).
- stage_hold  out  1  freeze the ID/EX and EX/MEM registers.
- mem_wb_bubble  out  1  insert a NOP into MEM/WB.
- mem_timeout_err  out  1  sticky timeout error.
- stall_count  out  CNT_W  cycles with pc_write=0.
- flush_count  out  CNT_W  cycles with if_id_flush=1.

Behaviour:
- Control outputs are combinational (Mealy) from state and inputs. State, timers, counters and err are registered.
- States are RUN, FLUSH, MEM_WAIT and ERROR.
- Default ("advance") outputs: pc_write=1, if_id_write=1, all flush/hold/bubble outputs=0.
- Load-use hazard (lu) = ex_memread && ex_rd!=0 && (ex_rd==id_rs1 || (id_uses_rs2 && ex_rd==id_rs2)).
- RUN, applying the first matching rule:
  - mem_req && !mem_ready: pc_write=0, if_id_write=0, stage_hold=1, mem_wb_bubble=1. Next state MEM_WAIT, timer=1, ret_flush=0.
  - ex_branch_taken: pc_write=1, if_id_flush=1, id_ex_flush=1. Next state FLUSH with fcnt=FLUSH_CYCLES-1 if FLUSH_CYCLES>1, else RUN.
  - lu: pc_write=0, if_id_write=0, id_ex_flush=1. Stay RUN. This is a single-cycle bubble; the hazard clears next cycle.
  - Otherwise: advance.
- FLUSH:
  - mem_req && !mem_ready takes priority: apply the same freeze outputs as in RUN, go to MEM_WAIT with ret_flush=1. fcnt is preserved.
  - Otherwise: pc_write=1, if_id_flush=1, id_ex_flush=1, fcnt decrements. Go to RUN when fcnt==1 before the decrement.
  - A new ex_branch_taken in FLUSH is ignored (EX already holds a bubble).
- MEM_WAIT:
  - !mem_ready: apply the freeze outputs and increment the timer. When the timer reaches MEM_TIMEOUT, go to ERROR.
  - mem_ready: the hold drops this cycle. Evaluate the RUN rules (branch/lu) if ret_flush=0, or the FLUSH outputs if ret_flush=1. The next state is the one those rules produce.
- ERROR: freeze outputs permanently and set mem_timeout_err=1. Only reset leaves ERROR.
- Counters:
  - stall_count increments in every non-reset cycle with pc_write=0.
  - flush_count increments in every cycle with if_id_flush=1.
  - Both saturate at all-ones and do not wrap.
- Reset (reset==0 sampled at a clk edge):
  - Registered values: state=RUN, fcnt=0, timer=0, ret_flush=0, counters=0, mem_timeout_err=0.
  - Outputs while reset is low: pc_write=0, if_id_write=0, if_id_flush=1, id_ex_flush=1, stage_hold=0, mem_wb_bubble=1.
  - Reset mid-MEM_WAIT, mid-FLUSH or in ERROR abandons that state; the first cycle after release is RUN.
- An ex_rd of x0 never causes a stall.

Decomposition:
- hazard_pkg holds:
  - the state enum: RUN, FLUSH, MEM_WAIT, ERROR;
  - the REG_ZERO constant;
  - the opcode constants R_TYPE 0110011, I_TYPE 0010011, LW 0000011, SW 0100011, BR 1100011, used by decode-side logic to drive id_uses_rs2.
- One combinational sub-module, load_use_detect, computes lu.

Test Plan:
- Load-use: ex_memread=1, ex_rd=5, id_rs1=5 for one cycle -> pc_write=0, if_id_write=0, id_ex_flush=1 that cycle; stall_count=1; the next cycle advances.
- x0 / rs2 gating: ex_rd=0, id_rs1=0 -> no stall. ex_rd=7, id_rs2=7, id_uses_rs2=0 -> no stall. Same with id_uses_rs2=1 -> stall.
- Branch with FLUSH_CYCLES=2: ex_branch_taken for one cycle -> if_id_flush=1 for exactly 2 cycles, flush_count=2. lu asserted in the same first cycle is ignored.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> stage_hold=1 for 3 cycles, drops in the ready cycle; stall_count=3; state back to RUN.
- Timeout with MEM_TIMEOUT=4: mem_ready held 0 -> ERROR after 4 wait cycles, mem_timeout_err=1 and held. reset=0 for one cycle -> err=0, counters=0, state RUN.
- Simultaneous events: mem stall while in FLUSH with fcnt=1 remaining -> freeze, then on mem_ready one flush cycle, then RUN.
